// File: rtl/weight_bias_loader_pkg.sv
// Shared widths for the weight/bias loader.
// Imported by the loader and its bench.
package weight_bias_loader_pkg;

   localparam int dataWidth = 16;
   localparam int cfgWidth  = 2*dataWidth+1;

endpackage

// File: rtl/weight_bias_loader.sv
// Streams per-neuron weight words then one bias word
// into registered outputs, flagging framing errors.
module weight_bias_loader
   import weight_bias_loader_pkg::*;
#(
   parameter int layerNo    = 1,
   parameter int numNeurons = 30,
   parameter int numWeight  = 128
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 s_valid,
   input  logic [dataWidth-1:0] s_data,
   input  logic                 s_last,
   output logic                 s_ready,
   output logic [dataWidth-1:0] weightValue,
   output logic                 weightValid,
   output logic [dataWidth-1:0] biasValue,
   output logic                 biasValid,
   output logic [cfgWidth-1:0]  config_layer_num,
   output logic [cfgWidth-1:0]  config_neuron_num,
   output logic                 busy,
   output logic                 load_done,
   output logic                 err
);

   localparam int WW = (numWeight  > 1) ? $clog2(numWeight)  : 1;
   localparam int NW = (numNeurons > 1) ? $clog2(numNeurons) : 1;

   localparam logic [WW-1:0] W_LAST = WW'(numWeight - 1);
   localparam logic [NW-1:0] N_LAST = NW'(numNeurons - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WEIGHT = 2'd1;
   localparam logic [1:0] S_BIAS   = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]           r_state;
   logic [WW-1:0]        r_wcnt;
   logic [NW-1:0]        r_ncnt;
   logic [dataWidth-1:0] r_wvalue;
   logic [dataWidth-1:0] r_bvalue;
   logic                 r_wvalid;
   logic                 r_bvalid;
   logic [cfgWidth-1:0]  r_nout;
   logic                 r_err;
   logic                 w_ready;
   logic                 w_beat;

   assign w_ready = (r_state == S_WEIGHT) ||
                    (r_state == S_BIAS);
   assign w_beat  = s_valid & w_ready;

   assign s_ready           = w_ready;
   assign busy              = (r_state != S_IDLE);
   assign load_done         = (r_state == S_DONE);
   assign weightValue       = r_wvalue;
   assign weightValid       = r_wvalid;
   assign biasValue         = r_bvalue;
   assign biasValid         = r_bvalid;
   assign config_neuron_num = r_nout;
   assign config_layer_num  = cfgWidth'(layerNo);
   assign err               = r_err;

   // Sequencer plus output registers; valids are single-cycle strobes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_wcnt   <= '0;
         r_ncnt   <= '0;
         r_wvalue <= '0;
         r_bvalue <= '0;
         r_wvalid <= 1'b0;
         r_bvalid <= 1'b0;
         r_nout   <= '0;
         r_err    <= 1'b0;
      end else begin
         r_wvalid <= 1'b0;
         r_bvalid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_WEIGHT;
                  r_wcnt  <= '0;
                  r_ncnt  <= '0;
                  r_err   <= 1'b0;
               end
            end
            S_WEIGHT: begin
               if (w_beat) begin
                  r_wvalue <= s_data;
                  r_wvalid <= 1'b1;
                  r_nout   <= cfgWidth'(r_ncnt);
                  if (s_last) r_err <= 1'b1;
                  if (r_wcnt == W_LAST) begin
                     r_wcnt  <= '0;
                     r_state <= S_BIAS;
                  end else begin
                     r_wcnt <= r_wcnt + 1'b1;
                  end
               end
            end
            S_BIAS: begin
               if (w_beat) begin
                  r_bvalue <= s_data;
                  r_bvalid <= 1'b1;
                  r_nout   <= cfgWidth'(r_ncnt);
                  if (r_ncnt == N_LAST) begin
                     r_state <= S_DONE;
                     if (!s_last) r_err <= 1'b1;
                  end else begin
                     r_ncnt  <= r_ncnt + 1'b1;
                     r_state <= S_WEIGHT;
                     if (s_last) r_err <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_weight_bias_loader.sv
// Randomized scoreboard bench for weight_bias_loader
// with a word-index reference model.
module tb_weight_bias_loader;
   import weight_bias_loader_pkg::*;

   localparam int NWT   = 4;
   localparam int NN    = 2;
   localparam int LAYER = 1;
   localparam int TOTAL = NN * (NWT + 1);

   typedef struct {
      bit  bias;
      int  val;
      int  nrn;
      int  cyc;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic                 s_valid;
   logic [dataWidth-1:0] s_data;
   logic                 s_last;
   logic                 s_ready;
   logic [dataWidth-1:0] weightValue;
   logic                 weightValid;
   logic [dataWidth-1:0] biasValue;
   logic                 biasValid;
   logic [cfgWidth-1:0]  config_layer_num;
   logic [cfgWidth-1:0]  config_neuron_num;
   logic                 busy;
   logic                 load_done;
   logic                 err;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   bit   m_err;

   weight_bias_loader #(
      .layerNo(LAYER),
      .numNeurons(NN),
      .numWeight(NWT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .s_valid(s_valid),
      .s_data(s_data),
      .s_last(s_last),
      .s_ready(s_ready),
      .weightValue(weightValue),
      .weightValid(weightValid),
      .biasValue(biasValue),
      .biasValid(biasValid),
      .config_layer_num(config_layer_num),
      .config_neuron_num(config_neuron_num),
      .busy(busy),
      .load_done(load_done),
      .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT strobes a valid.
   initial begin
      exp_t e;
      bit   exp_done;
      int   got;
      forever begin
         @(negedge clk);
         exp_done = 1'b0;
         if (weightValid && biasValid) begin
            chk("both_valids", 1, 0);
         end else if (weightValid || biasValid) begin
            if (sb.size() == 0) begin
               chk("spurious_valid", 1, 0);
            end else begin
               e = sb.pop_front();
               got = biasValid ? int'(biasValue)
                               : int'(weightValue);
               chk("beat_kind", biasValid, e.bias);
               chk("beat_value", got, e.val);
               chk("beat_neuron", config_neuron_num, e.nrn);
               chk("beat_latency", cyc, e.cyc);
               exp_done = e.bias && (e.nrn == NN - 1);
            end
         end
         if (load_done || exp_done)
            chk("load_done", load_done, exp_done);
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send(input int k, input int data,
                       input bit last, input bit gap,
                       input bit do_start);
      exp_t e;
      bit   acc;
      bit   fin;
      if (gap) begin
         s_valid = 1'b0;
         @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data  = dataWidth'(data);
      s_last  = last;
      start   = do_start;
      acc     = 1'b0;
      for (int t = 0; t < 50 && !acc; t++) begin
         @(negedge clk);
         if (s_ready) begin
            acc    = 1'b1;
            e.bias = (k % (NWT + 1)) == NWT;
            e.val  = data;
            e.nrn  = k / (NWT + 1);
            e.cyc  = cyc + 1;
            sb.push_back(e);
         end
         @(posedge clk); #1;
         start = 1'b0;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (!acc) chk("accept_timeout", 0, 1);
      fin = (k == TOTAL - 1);
      if ((fin && !last) || (!fin && last)) m_err = 1'b1;
      chk("err_after_beat", err, m_err);
   endtask

   task automatic abort_run();
      @(negedge clk); #1;
      rst = 1'b0;
      #1;
      chk("abort_wvalid", weightValid, 0);
      chk("abort_bvalid", biasValid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_wvalue", weightValue, 0);
      chk("abort_bvalue", biasValue, 0);
      chk("abort_neuron", config_neuron_num, 0);
      chk("abort_err", err, 0);
      sb.delete();
      @(posedge clk); #1;
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         s_valid = 1'b1;
         s_data  = dataWidth'($urandom_range(0, 65535));
         @(negedge clk);
         chk("post_abort_ready", s_ready, 0);
         chk("post_abort_busy", busy, 0);
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
   endtask

   // gap: 0 none, 1 every other cycle, 2 random
   task automatic run(input bit seq, input int gap,
                      input int bad_k, input bit fin_last,
                      input int start_k, input int abort_k);
      int  data;
      bit  last;
      bit  g;
      pulse_start();
      m_err = 1'b0;
      chk("run_busy", busy, 1);
      chk("run_err_cleared", err, 0);
      for (int k = 0; k < TOTAL; k++) begin
         data = seq ? k + 1 : int'($urandom_range(0, 65535));
         last = (k == TOTAL - 1) ? fin_last : (k == bad_k);
         g    = (gap == 1) ||
                (gap == 2 && $urandom_range(0, 1) == 1);
         send(k, data, last, g, k == start_k);
         if (k == abort_k) begin
            abort_run();
            return;
         end
      end
      @(negedge clk);
      @(negedge clk); #1;
      chk("end_busy", busy, 0);
      chk("end_err", err, m_err);
      chk("sb_drained", sb.size(), 0);
   endtask

   initial begin
      rst     = 1'b0;
      start   = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      s_last  = 1'b0;
      m_err   = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      chk("rst_wvalid", weightValid, 0);
      chk("rst_bvalid", biasValid, 0);
      chk("rst_done", load_done, 0);
      chk("rst_err", err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", s_ready, 0);
      chk("rst_wvalue", weightValue, 0);
      chk("rst_bvalue", biasValue, 0);
      chk("rst_neuron", config_neuron_num, 0);
      chk("layer_num", config_layer_num, LAYER);
      rst = 1'b1;
      @(posedge clk); #1;

      run(1, 0, -1, 1, -1, -1);
      run(1, 1, -1, 1, -1, -1);
      run(1, 0,  2, 1, -1, -1);
      run(1, 0, -1, 1, -1, -1);
      run(1, 0, -1, 1,  1, -1);
      run(1, 0, -1, 1, -1,  5);
      run(1, 0, -1, 1, -1, -1);
      run(1, 0, -1, 0, -1, -1);
      for (int r = 0; r < 6; r++)
         run(0, 2, -1, 1, -1, -1);
      chk("layer_num_end", config_layer_num, LAYER);

      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
